// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I datapath.
// Walks each instruction through FETCH/DECODE/EXECUTE/[MEM/WB]/COMMIT and
// drives the datapath strobes and mux selects from the current state and the
// instruction class latched at the end of DECODE. Data-memory accesses wait
// for dmem_ready and trap after MEM_TIMEOUT idle cycles; TRAP is absorbing
// until reset.
// Optional build macro CTRL_PERF_CNT_EN adds the cycle_cnt / retire_cnt
// performance counters (width CNT_W).

module mc_ctrl_fsm #(
`ifdef CTRL_PERF_CNT_EN
  parameter int unsigned CNT_W       = 32,
`endif
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_code,
  input  logic        dmem_ready,
  output logic        pcen,
  output logic        regFileWe,
  output logic [3:0]  alucode,
  output logic [2:0]  Lcode,
  output logic [2:0]  wdSrcMuxSel,
  output logic        aluSrcMuxSel,
  output logic [1:0]  pcSrcMuxSel,
  output logic        dataWe,
  output logic        dataRe,
  output logic        illegal,
  output logic [2:0]  state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  // RV32I major opcodes
  localparam logic [6:0] OpcR     = 7'b0110011;
  localparam logic [6:0] OpcI     = 7'b0010011;
  localparam logic [6:0] OpcL     = 7'b0000011;
  localparam logic [6:0] OpcS     = 7'b0100011;
  localparam logic [6:0] OpcB     = 7'b1100011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcJal   = 7'b1101111;
  localparam logic [6:0] OpcJalr  = 7'b1100111;

  // ALU code for plain addition ({funct7[5], funct3} of ADD)
  localparam logic [3:0] AluAdd = 4'b0000;

  // MEM wait limit, 8 bits covers the legal 1..255 range
  localparam logic [7:0] TmoLimit = 8'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StCommit  = 3'd5,
    StTrap    = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    OpR, OpI, OpL, OpS, OpB, OpLui, OpAuipc, OpJal, OpJalr, OpBad
  } op_e;

  state_e     state_q, state_d;
  op_e        op_q, dec_op;
  logic [2:0] f3_q;
  logic       f7b5_q;
  logic [7:0] tmo_q, tmo_d;
  logic       illegal_q;

  // Decoded per-class controls, derived from the latched instruction
  logic       is_load, is_store, does_write, alu_src;
  logic [2:0] wd_sel;
  logic [1:0] pc_src;
  logic [3:0] alu_code;

  // Only opcode, funct3 and funct7[5] steer control; the rest is datapath
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};

  // Map the raw opcode onto an instruction class
  always_comb begin
    dec_op = OpBad;
    case (instr_code[6:0])
      OpcR:     dec_op = OpR;
      OpcI:     dec_op = OpI;
      OpcL:     dec_op = OpL;
      OpcS:     dec_op = OpS;
      OpcB:     dec_op = OpB;
      OpcLui:   dec_op = OpLui;
      OpcAuipc: dec_op = OpAuipc;
      OpcJal:   dec_op = OpJal;
      OpcJalr:  dec_op = OpJalr;
      default:  dec_op = OpBad;
    endcase
  end

  // Per-class datapath controls used from EXECUTE onwards
  always_comb begin
    is_load    = (op_q == OpL);
    is_store   = (op_q == OpS);
    does_write = 1'b0;
    alu_src    = 1'b0;
    wd_sel     = 3'd0;
    pc_src     = 2'd0;
    alu_code   = AluAdd;
    case (op_q)
      OpR: begin
        does_write = 1'b1;
        alu_code   = {f7b5_q, f3_q};
      end
      OpI: begin
        does_write = 1'b1;
        alu_src    = 1'b1;
        // funct7[5] only distinguishes SRAI from SRLI; elsewhere it is immediate bits
        alu_code   = (f3_q == 3'b101) ? {f7b5_q, f3_q} : {1'b0, f3_q};
      end
      OpL, OpS: alu_src = 1'b1;
      OpB: pc_src = 2'd1;
      OpLui: begin
        does_write = 1'b1;
        wd_sel     = 3'd2;
      end
      OpAuipc: begin
        does_write = 1'b1;
        wd_sel     = 3'd3;
        pc_src     = 2'd1;
      end
      OpJal: begin
        does_write = 1'b1;
        wd_sel     = 3'd4;
        pc_src     = 2'd2;
      end
      OpJalr: begin
        does_write = 1'b1;
        alu_src    = 1'b1;
        wd_sel     = 3'd4;
        pc_src     = 2'd2;
      end
      default: ;
    endcase
  end

  // Next-state and MEM timeout counter
  always_comb begin
    state_d = state_q;
    tmo_d   = 8'd0;
    unique case (state_q)
      StFetch:   state_d = StDecode;
      StDecode:  state_d = (dec_op == OpBad) ? StTrap : StExecute;
      StExecute: state_d = (is_load || is_store) ? StMem : StCommit;
      StMem: begin
        if (dmem_ready) begin
          state_d = is_load ? StWb : StCommit;
        end else if (tmo_q + 8'd1 == TmoLimit) begin
          state_d = StTrap;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StWb:      state_d = StCommit;
      StCommit:  state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StTrap;
    endcase
  end

  // State, latched instruction class, timeout counter and sticky trap flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      op_q      <= OpBad;
      f3_q      <= 3'd0;
      f7b5_q    <= 1'b0;
      tmo_q     <= 8'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (state_q == StDecode) begin
        op_q   <= dec_op;
        f3_q   <= instr_code[14:12];
        f7b5_q <= instr_code[30];
      end
      if (state_d == StTrap) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Datapath strobes and selects, purely from the current state
  always_comb begin
    pcen         = 1'b0;
    regFileWe    = 1'b0;
    alucode      = 4'd0;
    Lcode        = 3'd0;
    wdSrcMuxSel  = 3'd0;
    aluSrcMuxSel = 1'b0;
    pcSrcMuxSel  = 2'd0;
    dataWe       = 1'b0;
    dataRe       = 1'b0;
    unique case (state_q)
      StExecute: begin
        alucode      = alu_code;
        aluSrcMuxSel = alu_src;
        pcSrcMuxSel  = pc_src;
        if (does_write) begin
          regFileWe   = 1'b1;
          wdSrcMuxSel = wd_sel;
        end
      end
      StMem: begin
        alucode      = alu_code;
        aluSrcMuxSel = alu_src;
        pcSrcMuxSel  = pc_src;
        Lcode        = f3_q;
        dataRe       = is_load;
        dataWe       = is_store;
      end
      StWb: begin
        alucode      = alu_code;
        aluSrcMuxSel = alu_src;
        pcSrcMuxSel  = pc_src;
        Lcode        = f3_q;
        regFileWe    = 1'b1;
        wdSrcMuxSel  = 3'd1;
      end
      StCommit: begin
        // Select was already stable through EXECUTE..WB, so PC loads a settled value
        pcSrcMuxSel = pc_src;
        pcen        = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, retire_q;

  // Free-running cycle count (frozen in TRAP) and retired-instruction count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if (state_q != StTrap) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (state_q == StCommit) begin
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm (MEM_TIMEOUT = 16).

module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_code;
  logic        dmem_ready;
  logic        pcen, regFileWe, aluSrcMuxSel, dataWe, dataRe, illegal;
  logic [3:0]  alucode;
  logic [2:0]  Lcode, wdSrcMuxSel, state_o;
  logic [1:0]  pcSrcMuxSel;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  always #5 clk = ~clk;

  mc_ctrl_fsm #(
    .MEM_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_code  (instr_code),
    .dmem_ready  (dmem_ready),
    .pcen        (pcen),
    .regFileWe   (regFileWe),
    .alucode     (alucode),
    .Lcode       (Lcode),
    .wdSrcMuxSel (wdSrcMuxSel),
    .aluSrcMuxSel(aluSrcMuxSel),
    .pcSrcMuxSel (pcSrcMuxSel),
    .dataWe      (dataWe),
    .dataRe      (dataRe),
    .illegal     (illegal),
    .state_o     (state_o)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .retire_cnt  (retire_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Results gathered by run_instr
  int         r_cycles, r_n_we, r_n_pcen, r_n_re, r_n_dwe, r_pcsrc_bad;
  logic [3:0] r_alu_ex;
  logic       r_asrc_ex;
  logic [2:0] r_wd_we, r_lcode_we, r_st_we;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        asrc;
    logic [2:0]  wd;
    logic [1:0]  pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH until back in FETCH or in TRAP (bounded).
  // ready_at: MEM cycle index at which dmem_ready is raised (-1 = never).
  // ready_idle: level driven on dmem_ready outside MEM (must be ignored).
  task automatic run_instr(input logic [31:0] instr, input int ready_at, input logic ready_idle,
                           input logic [1:0] exp_pcsrc, input int max_cyc);
    int mem_idx;
    mem_idx     = 0;
    instr_code  = instr;
    r_cycles    = 0;
    r_n_we      = 0;
    r_n_pcen    = 0;
    r_n_re      = 0;
    r_n_dwe     = 0;
    r_pcsrc_bad = 0;
    r_alu_ex    = 4'hf;
    r_asrc_ex   = 1'bx;
    r_wd_we     = 3'd7;
    r_lcode_we  = 3'd7;
    r_st_we     = 3'd7;
    do begin
      r_cycles++;
      if (state_o == 3'd3) begin
        dmem_ready = (mem_idx == ready_at);
        mem_idx++;
      end else begin
        dmem_ready = ready_idle;
      end
      if (pcen) r_n_pcen++;
      if (regFileWe) begin
        r_n_we++;
        r_wd_we    = wdSrcMuxSel;
        r_lcode_we = Lcode;
        r_st_we    = state_o;
      end
      if (dataRe) r_n_re++;
      if (dataWe) r_n_dwe++;
      if (state_o == 3'd2) begin
        r_alu_ex  = alucode;
        r_asrc_ex = aluSrcMuxSel;
      end
      if (state_o >= 3'd2 && state_o <= 3'd5 && pcSrcMuxSel !== exp_pcsrc) r_pcsrc_bad++;
      step();
    end while (state_o != 3'd0 && state_o != 3'd6 && r_cycles < max_cyc);
    dmem_ready = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_state"}, state_o, 3'd0);
    chk({tag, "_illegal"}, illegal, 1'b0);
    step();
    rst = 1'b1;
  endtask

  initial begin
    int bad;

    vecs[0] = '{32'h002081B3, 4'h0, 1'b0, 3'd0, 2'd0};  // ADD
    vecs[1] = '{32'h40208133, 4'h8, 1'b0, 3'd0, 2'd0};  // SUB
    vecs[2] = '{32'h0020D0B3, 4'h5, 1'b0, 3'd0, 2'd0};  // SRL
    vecs[3] = '{32'h4030D093, 4'hD, 1'b1, 3'd0, 2'd0};  // SRAI
    vecs[4] = '{32'hC0000093, 4'h0, 1'b1, 3'd0, 2'd0};  // ADDI, imm bit30 set
    vecs[5] = '{32'h123450B7, 4'h0, 1'b0, 3'd2, 2'd0};  // LUI
    vecs[6] = '{32'h00001097, 4'h0, 1'b0, 3'd3, 2'd1};  // AUIPC
    vecs[7] = '{32'h008000EF, 4'h0, 1'b0, 3'd4, 2'd2};  // JAL
    vecs[8] = '{32'h000080E7, 4'h0, 1'b1, 3'd4, 2'd2};  // JALR

    rst        = 1'b0;
    instr_code = 32'h002081B3;
    dmem_ready = 1'b0;
    step();
    step();
    chk("rst_state", state_o, 3'd0);
    chk("rst_strobes", {pcen, regFileWe, dataWe, dataRe, illegal}, 5'b0);
    chk("rst_sels", {alucode, Lcode, wdSrcMuxSel, aluSrcMuxSel, pcSrcMuxSel}, 13'b0);
    rst = 1'b1;

    // ADD x3,x1,x2 walked state by state
    chk("add_fetch", {state_o, pcen, regFileWe}, {3'd0, 2'b00});
    step();
    chk("add_decode", {state_o, pcen, regFileWe}, {3'd1, 2'b00});
    step();
    chk("add_exec", {state_o, pcen, regFileWe, wdSrcMuxSel, alucode}, {3'd2, 2'b01, 3'd0, 4'h0});
    step();
    chk("add_commit", {state_o, pcen, regFileWe, pcSrcMuxSel}, {3'd5, 2'b10, 2'd0});
    step();
    chk("add_back", state_o, 3'd0);

    // Register/immediate/U/J classes from a table
    for (int i = 0; i < 9; i++) begin
      run_instr(vecs[i].instr, -1, 1'b0, vecs[i].pc, 20);
      chk($sformatf("v%0d_cycles", i), r_cycles, 4);
      chk($sformatf("v%0d_we", i), {r_n_we, r_st_we, r_wd_we}, {32'd1, 3'd2, vecs[i].wd});
      chk($sformatf("v%0d_alu", i), {r_alu_ex, r_asrc_ex}, {vecs[i].alu, vecs[i].asrc});
      chk($sformatf("v%0d_pc", i), {r_n_pcen, r_pcsrc_bad}, {32'd1, 32'd0});
    end

    // BEQ: no write anywhere, branch target selected EXECUTE..COMMIT
    run_instr(32'h00208463, -1, 1'b0, 2'd1, 20);
    chk("beq_cycles", r_cycles, 4);
    chk("beq_we", r_n_we, 0);
    chk("beq_pcsrc_hold", r_pcsrc_bad, 0);
    chk("beq_pcen", r_n_pcen, 1);

    // LW, ready on the 4th MEM cycle (3 wait cycles), ready held high outside MEM
    run_instr(32'h0040A283, 3, 1'b1, 2'd0, 30);
    chk("lw_cycles", r_cycles, 9);
    chk("lw_re_cycles", r_n_re, 4);
    chk("lw_we", {r_n_we, r_st_we, r_wd_we, r_lcode_we}, {32'd1, 3'd4, 3'd1, 3'b010});
    chk("lw_asrc", r_asrc_ex, 1'b1);
    chk("lw_pcen", {r_n_pcen, r_n_dwe}, {32'd1, 32'd0});

    // SW with immediate ready, then with ready on the last legal MEM cycle
    run_instr(32'h0020A423, 0, 1'b0, 2'd0, 30);
    chk("sw_cycles", r_cycles, 5);
    chk("sw_counts", {r_n_dwe, r_n_we, r_n_pcen}, {32'd1, 32'd0, 32'd1});
    run_instr(32'h0020A423, 15, 1'b0, 2'd0, 40);
    chk("sw_late_cycles", r_cycles, 20);
    chk("sw_late_end", {state_o, illegal}, {3'd0, 1'b0});

    // SW with no ready: trap after 16 MEM cycles
    run_instr(32'h0020A423, -1, 1'b0, 2'd0, 40);
    chk("sw_tmo_cycles", r_cycles, 19);
    chk("sw_tmo_state", {state_o, illegal}, {3'd6, 1'b1});
    chk("sw_tmo_counts", {r_n_dwe, r_n_pcen, r_n_we}, {32'd16, 32'd0, 32'd0});
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (dataWe || pcen || state_o != 3'd6) bad++;
      step();
    end
    chk("sw_tmo_after", bad, 0);
    pulse_reset("rst1");

    // Unknown opcode traps from DECODE and stays there
    run_instr(32'h0000007F, -1, 1'b0, 2'd0, 10);
    chk("bad_op_cycles", r_cycles, 2);
    chk("bad_op_state", {state_o, illegal}, {3'd6, 1'b1});
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      dmem_ready = i[0];
      if (!illegal || state_o != 3'd6 || pcen || regFileWe || dataWe || dataRe) bad++;
      step();
    end
    dmem_ready = 1'b0;
    chk("bad_op_sticky", bad, 0);
    pulse_reset("rst2");

    // Async reset in the middle of a store's MEM phase
    instr_code = 32'h0020A423;
    step();
    step();
    step();
    chk("mid_mem_before", {state_o, dataWe}, {3'd3, 1'b1});
    rst = 1'b0;
    #1;
    chk("mid_mem_after", {state_o, dataWe, pcen, regFileWe}, {3'd0, 3'b000});
    step();
    rst = 1'b1;

`ifdef CTRL_PERF_CNT_EN
    chk("perf_reset", {cycle_cnt, retire_cnt}, 64'd0);
`endif
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      run_instr(32'h002081B3, -1, 1'b0, 2'd0, 20);
      if (r_cycles != 4 || r_n_pcen != 1) bad++;
    end
    chk("three_adds", bad, 0);
`ifdef CTRL_PERF_CNT_EN
    chk("perf_retire", retire_cnt, 32'd3);
    chk("perf_cycle", cycle_cnt, 32'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
